// File: rtl/digit_pkg.sv
// Shared constants and FSM state type for the 11x11 digit recogniser.
// Template ROM address layout is {tmpl_idx, pix_idx}.
package digit_pkg;

   localparam int SIDE   = 11;
   localparam int N_PIX  = SIDE * SIDE;
   localparam int N_TMPL = 10;
   localparam int PIX_W  = 8;
   localparam int ACC_W  = 15;
   localparam int PIX_AW = 7;
   localparam int TMPL_W = 4;
   localparam int TADR_W = TMPL_W + PIX_AW;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      CMP   = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/pixel_abs_diff.sv
// Combinational unsigned absolute difference of two pixels.
module pixel_abs_diff
   import digit_pkg::*;
(
   input  logic [PIX_W-1:0] a,
   input  logic [PIX_W-1:0] b,
   output logic [PIX_W-1:0] diff
);

   assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/digit_match_sequencer.sv
// Sweeps the 10 digit templates through one shared difference engine, sums
// the 121 pixel differences per template and reports the lowest-scoring digit.
module digit_match_sequencer
   import digit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [PIX_AW-1:0] pix_addr,
   input  logic [PIX_W-1:0]  pix_data,
   output logic [TADR_W-1:0] tmpl_addr,
   input  logic [PIX_W-1:0]  tmpl_data,
   output logic              busy,
   output logic              result_valid,
   output logic [TMPL_W-1:0] digit,
   output logic [ACC_W-1:0]  best_score
);

   localparam logic [PIX_AW-1:0] LAST_PIX  = PIX_AW'(N_PIX - 1);
   localparam logic [TMPL_W-1:0] LAST_TMPL = TMPL_W'(N_TMPL - 1);

   state_e              state, state_n;
   logic [TMPL_W-1:0]   t, t_n;
   logic [PIX_AW-1:0]   pix_idx, pix_idx_n;
   logic                rd_vld, rd_vld_n;
   logic [ACC_W-1:0]    acc, acc_n;
   logic [ACC_W-1:0]    best, best_n;
   logic [TMPL_W-1:0]   best_idx, best_idx_n;
   logic                busy_n, result_valid_n;
   logic [TMPL_W-1:0]   digit_n;
   logic [ACC_W-1:0]    best_score_n;
   logic [PIX_W-1:0]    diff;

   pixel_abs_diff u_abs_diff (
      .a    (pix_data),
      .b    (tmpl_data),
      .diff (diff)
   );

   // Addresses are only driven while issuing reads; elsewhere they rest at 0.
   assign pix_addr  = (state == RUN) ? pix_idx : '0;
   assign tmpl_addr = (state == RUN) ? {t, pix_idx} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         t            <= '0;
         pix_idx      <= '0;
         rd_vld       <= 1'b0;
         acc          <= '0;
         best         <= '0;
         best_idx     <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         digit        <= '0;
         best_score   <= '0;
      end else begin
         state        <= state_n;
         t            <= t_n;
         pix_idx      <= pix_idx_n;
         rd_vld       <= rd_vld_n;
         acc          <= acc_n;
         best         <= best_n;
         best_idx     <= best_idx_n;
         busy         <= busy_n;
         result_valid <= result_valid_n;
         digit        <= digit_n;
         best_score   <= best_score_n;
      end
   end

   always_comb begin
      state_n        = state;
      t_n            = t;
      pix_idx_n      = pix_idx;
      rd_vld_n       = (state == RUN);
      acc_n          = acc;
      best_n         = best;
      best_idx_n     = best_idx;
      busy_n         = busy;
      result_valid_n = 1'b0;
      digit_n        = digit;
      best_score_n   = best_score;

      // Read data arrives one cycle after its address, so rd_vld trails RUN.
      if (rd_vld) begin
         acc_n = acc + ACC_W'(diff);
      end

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n    = RUN;
               t_n        = '0;
               pix_idx_n  = '0;
               acc_n      = '0;
               best_n     = '1;
               best_idx_n = '0;
               busy_n     = 1'b1;
            end
         end
         RUN: begin
            if (pix_idx == LAST_PIX) begin
               pix_idx_n = '0;
               state_n   = DRAIN;
            end else begin
               pix_idx_n = pix_idx + PIX_AW'(1);
            end
         end
         DRAIN: begin
            state_n = CMP;
         end
         CMP: begin
            // Strict compare keeps the lower template index on a tie.
            if (acc < best) begin
               best_n     = acc;
               best_idx_n = t;
            end
            acc_n = '0;
            if (t == LAST_TMPL) begin
               state_n = DONE;
            end else begin
               t_n       = t + TMPL_W'(1);
               pix_idx_n = '0;
               state_n   = RUN;
            end
         end
         DONE: begin
            digit_n        = best_idx;
            best_score_n   = best;
            result_valid_n = 1'b1;
            busy_n         = 1'b0;
            state_n        = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Abort overrides everything, including a start in the same cycle.
      if (abort) begin
         state_n        = IDLE;
         rd_vld_n       = 1'b0;
         busy_n         = 1'b0;
         result_valid_n = 1'b0;
         digit_n        = digit;
         best_score_n   = best_score;
      end
   end

endmodule
